mbc_control_unit: RTL and testbench

Instruction sequencer for the 16-bit basic computer. Fetches instructions from memory over a req/ack handshake, decodes them from the IR, and walks each instruction through timing states. It drives the ALU operation code, the register load/increment strobes and the memory strobes of the datapath. Multi-bit register-reference instructions execute one micro-op per cycle, and skips are applied to the PC.

---
 rtl/mbc_pkg.sv | 94 +++++++++
 rtl/mbc_control_unit_rr_picker.sv | 24 ++
 rtl/mbc_control_unit.sv | 189 ++++++++++++++++++
 tb/tb_mbc_control_unit.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/mbc_pkg.sv
// Shared definitions for the basic computer: opcodes, ALU codes, micro-op
// bit positions, sequencer states and write-data source encoding.
package mbc_pkg;

   // Memory-reference opcodes (ir[14:12]); 111 is register-ref / I/O
   localparam logic [2:0] OP_AND = 3'b000;
   localparam logic [2:0] OP_ADD = 3'b001;
   localparam logic [2:0] OP_LDA = 3'b010;
   localparam logic [2:0] OP_STA = 3'b011;
   localparam logic [2:0] OP_BUN = 3'b100;
   localparam logic [2:0] OP_BSA = 3'b101;
   localparam logic [2:0] OP_ISZ = 3'b110;
   localparam logic [2:0] OP_RIO = 3'b111;

   // ALU operation select
   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_ADD = 4'b0001;
   localparam logic [3:0] ALU_LDA = 4'b0010;
   localparam logic [3:0] ALU_CMA = 4'b0011;
   localparam logic [3:0] ALU_CIR = 4'b0100;
   localparam logic [3:0] ALU_CIL = 4'b0101;
   localparam logic [3:0] ALU_CLA = 4'b0110;
   localparam logic [3:0] ALU_INC = 4'b0111;
   localparam logic [3:0] ALU_CLE = 4'b1000;
   localparam logic [3:0] ALU_CME = 4'b1001;
   localparam logic [3:0] ALU_SPA = 4'b1010;
   localparam logic [3:0] ALU_SNA = 4'b1011;
   localparam logic [3:0] ALU_SZA = 4'b1100;
   localparam logic [3:0] ALU_SZE = 4'b1101;

   // Register-reference micro-op bit positions in ir[11:0]
   localparam logic [3:0] RB_CLA = 4'd11;
   localparam logic [3:0] RB_CLE = 4'd10;
   localparam logic [3:0] RB_CMA = 4'd9;
   localparam logic [3:0] RB_CME = 4'd8;
   localparam logic [3:0] RB_CIR = 4'd7;
   localparam logic [3:0] RB_CIL = 4'd6;
   localparam logic [3:0] RB_INC = 4'd5;
   localparam logic [3:0] RB_SPA = 4'd4;
   localparam logic [3:0] RB_SNA = 4'd3;
   localparam logic [3:0] RB_SZA = 4'd2;
   localparam logic [3:0] RB_SZE = 4'd1;
   localparam logic [3:0] RB_HLT = 4'd0;

   // Memory write data source
   localparam logic [1:0] WSEL_DR = 2'd0;
   localparam logic [1:0] WSEL_AC = 2'd1;
   localparam logic [1:0] WSEL_PC = 2'd2;

   typedef enum logic [3:0] {
      S_IDLE, S_T0, S_T1, S_T2, S_IND, S_RD, S_EXEC, S_WR, S_BSA2, S_ISZ_INC, S_RR
   } state_t;

   // State reached once the effective address is in AR
   function automatic state_t dispatch(input logic [2:0] opc);
      case (opc)
         OP_STA, OP_BSA: dispatch = S_WR;
         OP_BUN:         dispatch = S_EXEC;
         default:        dispatch = S_RD;
      endcase
   endfunction

   // ALU code for one register-reference micro-op (HLT drives the default)
   function automatic logic [3:0] rr_alu_code(input logic [3:0] idx);
      case (idx)
         RB_CLA:  rr_alu_code = ALU_CLA;
         RB_CLE:  rr_alu_code = ALU_CLE;
         RB_CMA:  rr_alu_code = ALU_CMA;
         RB_CME:  rr_alu_code = ALU_CME;
         RB_CIR:  rr_alu_code = ALU_CIR;
         RB_CIL:  rr_alu_code = ALU_CIL;
         RB_INC:  rr_alu_code = ALU_INC;
         RB_SPA:  rr_alu_code = ALU_SPA;
         RB_SNA:  rr_alu_code = ALU_SNA;
         RB_SZA:  rr_alu_code = ALU_SZA;
         RB_SZE:  rr_alu_code = ALU_SZE;
         default: rr_alu_code = ALU_AND;
      endcase
   endfunction

   function automatic logic rr_writes_ac(input logic [3:0] idx);
      return (idx == RB_CLA) || (idx == RB_CMA) || (idx == RB_CIR) ||
             (idx == RB_CIL) || (idx == RB_INC);
   endfunction

   function automatic logic rr_writes_e(input logic [3:0] idx);
      return (idx == RB_CLE) || (idx == RB_CME) || (idx == RB_CIR) || (idx == RB_CIL);
   endfunction

   function automatic logic rr_is_skip(input logic [3:0] idx);
      return (idx >= RB_SZE) && (idx <= RB_SPA);
   endfunction

endpackage

// File: rtl/mbc_control_unit_rr_picker.sv
// Picks the highest pending register-reference micro-op and reports
// whether it is the last one left.
module mbc_rr_picker (
   input  logic [11:0] mask,
   output logic [3:0]  idx,
   output logic [11:0] clr,
   output logic        last
);

   // Ascending scan so the highest set bit is the one that sticks
   always_comb begin
      idx = 4'd0;
      clr = 12'd0;
      for (int b = 0; b < 12; b++) begin
         if (mask[b]) begin
            idx    = 4'(b);
            clr    = 12'd0;
            clr[b] = 1'b1;
         end
      end
      last = ((mask & ~clr) == 12'd0);
   end

endmodule

// File: rtl/mbc_control_unit.sv
// Instruction sequencer: fetch, decode and timing-state walk for the
// 16-bit basic computer. Memory uses req/ack: mem_req (with mem_we and
// mem_wsel) is held high in T1/IND/RD/WR until mem_ack is sampled high;
// load strobes fire combinationally in that ack cycle, and mem_ack while
// mem_req is low is ignored.
module mbc_control_unit
   import mbc_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [15:0] ir,
   input  logic        alu_inc,
   input  logic        dr_zero,
   input  logic        mem_ack,
   output logic [3:0]  alu_code,
   output logic        ar_ld_pc,
   output logic        ar_ld_ir,
   output logic        ar_ld_mem,
   output logic        ar_inc,
   output logic        pc_inc,
   output logic        pc_ld_ar,
   output logic        ir_ld,
   output logic        dr_ld,
   output logic        dr_inc,
   output logic        ac_ld,
   output logic        e_ld,
   output logic        mem_req,
   output logic        mem_we,
   output logic [1:0]  mem_wsel,
   output logic        halted,
   output state_t      state
);

   state_t      next;
   logic [11:0] rr_mask;
   logic        skip_pending;
   logic [3:0]  rr_idx;
   logic [11:0] rr_clr;
   logic        rr_last;
   logic        rr_skip;

   wire       ind = ir[15];
   wire [2:0] opc = ir[14:12];

   mbc_rr_picker u_picker (
      .mask (rr_mask),
      .idx  (rr_idx),
      .clr  (rr_clr),
      .last (rr_last)
   );

   assign rr_skip = rr_is_skip(rr_idx);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= next;
   end

   // Pending micro-op mask and accumulated skip for register-ref instructions
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_mask      <= 12'd0;
         skip_pending <= 1'b0;
      end else if (state == S_T2 && opc == OP_RIO && !ind) begin
         rr_mask      <= ir[11:0];
         skip_pending <= 1'b0;
      end else if (state == S_RR) begin
         rr_mask      <= rr_mask & ~rr_clr;
         skip_pending <= skip_pending | (rr_skip & alu_inc);
      end
   end

   // Next state and strobes
   always_comb begin
      next      = state;
      alu_code  = ALU_AND;
      ar_ld_pc  = 1'b0;
      ar_ld_ir  = 1'b0;
      ar_ld_mem = 1'b0;
      ar_inc    = 1'b0;
      pc_inc    = 1'b0;
      pc_ld_ar  = 1'b0;
      ir_ld     = 1'b0;
      dr_ld     = 1'b0;
      dr_inc    = 1'b0;
      ac_ld     = 1'b0;
      e_ld      = 1'b0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_wsel  = WSEL_DR;
      halted    = 1'b0;
      case (state)
         S_IDLE: begin
            halted = 1'b1;
            if (start) next = S_T0;
         end
         S_T0: begin
            ar_ld_pc = 1'b1;
            next     = S_T1;
         end
         S_T1: begin
            mem_req = 1'b1;
            if (mem_ack) begin
               ir_ld  = 1'b1;
               pc_inc = 1'b1;
               next   = S_T2;
            end
         end
         S_T2: begin
            if (opc == OP_RIO) begin
               // I/O instructions execute as NOP; an empty mask is a NOP too
               if (!ind && ir[11:0] != 12'd0) next = S_RR;
               else                           next = S_T0;
            end else begin
               ar_ld_ir = 1'b1;
               next     = ind ? S_IND : dispatch(opc);
            end
         end
         S_IND: begin
            mem_req = 1'b1;
            if (mem_ack) begin
               ar_ld_mem = 1'b1;
               next      = dispatch(opc);
            end
         end
         S_RD: begin
            mem_req = 1'b1;
            if (mem_ack) begin
               dr_ld = 1'b1;
               next  = (opc == OP_ISZ) ? S_ISZ_INC : S_EXEC;
            end
         end
         S_EXEC: begin
            if (opc == OP_BUN) begin
               pc_ld_ar = 1'b1;
            end else begin
               alu_code = {1'b0, opc};
               ac_ld    = 1'b1;
               e_ld     = (opc == OP_ADD);
            end
            next = S_T0;
         end
         S_ISZ_INC: begin
            dr_inc = 1'b1;
            next   = S_WR;
         end
         S_WR: begin
            mem_req = 1'b1;
            mem_we  = 1'b1;
            case (opc)
               OP_STA:  mem_wsel = WSEL_AC;
               OP_BSA:  mem_wsel = WSEL_PC;
               default: mem_wsel = WSEL_DR;
            endcase
            if (mem_ack) begin
               if (opc == OP_BSA) begin
                  ar_inc = 1'b1;
                  next   = S_BSA2;
               end else begin
                  pc_inc = (opc == OP_ISZ) && dr_zero;
                  next   = S_T0;
               end
            end
         end
         S_BSA2: begin
            pc_ld_ar = 1'b1;
            next     = S_T0;
         end
         S_RR: begin
            if (rr_mask == 12'd0) begin
               next = S_T0;
            end else begin
               alu_code = rr_alu_code(rr_idx);
               ac_ld    = rr_writes_ac(rr_idx);
               e_ld     = rr_writes_e(rr_idx);
               // One PC increment at most, after all earlier micro-ops
               if (rr_last) begin
                  pc_inc = skip_pending | (rr_skip & alu_inc);
                  next   = (rr_idx == RB_HLT) ? S_IDLE : S_T0;
               end
            end
         end
         default: next = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_mbc_control_unit.sv
// Directed, table-driven bench for mbc_control_unit: one record per clock
// cycle with inputs and hand-computed expected outputs, plus a reset
// asserted mid-fetch.
module tb_mbc_control_unit;
   import mbc_pkg::*;

   // Expected-strobe bit masks: {halted, ar_ld_pc, ar_ld_ir, ar_ld_mem, ar_inc,
   // pc_inc, pc_ld_ar, ir_ld, dr_ld, dr_inc, ac_ld, e_ld, mem_req, mem_we}
   localparam logic [13:0] H    = 14'h2000;
   localparam logic [13:0] APC  = 14'h1000;
   localparam logic [13:0] AIR  = 14'h0800;
   localparam logic [13:0] AMEM = 14'h0400;
   localparam logic [13:0] AINC = 14'h0200;
   localparam logic [13:0] PINC = 14'h0100;
   localparam logic [13:0] PLD  = 14'h0080;
   localparam logic [13:0] IRL  = 14'h0040;
   localparam logic [13:0] DRL  = 14'h0020;
   localparam logic [13:0] DRI  = 14'h0010;
   localparam logic [13:0] ACL  = 14'h0008;
   localparam logic [13:0] EL   = 14'h0004;
   localparam logic [13:0] RQ   = 14'h0002;
   localparam logic [13:0] WE   = 14'h0001;

   typedef struct {
      state_t      st;
      logic        start;
      logic [15:0] ir;
      logic        ack;
      logic        ainc;
      logic        dz;
      logic [3:0]  alu;
      logic [13:0] strb;
      logic [1:0]  wsel;
   } vec_t;

   logic        clk, rst_n, start, alu_inc, dr_zero, mem_ack;
   logic [15:0] ir;
   logic [3:0]  alu_code;
   logic        ar_ld_pc, ar_ld_ir, ar_ld_mem, ar_inc, pc_inc, pc_ld_ar;
   logic        ir_ld, dr_ld, dr_inc, ac_ld, e_ld, mem_req, mem_we, halted;
   logic [1:0]  mem_wsel;
   state_t      state;
   logic [13:0] strb;

   vec_t vecs[$];
   int   checks = 0;
   int   errors = 0;

   mbc_control_unit dut (
      .clk(clk), .rst_n(rst_n), .start(start), .ir(ir), .alu_inc(alu_inc),
      .dr_zero(dr_zero), .mem_ack(mem_ack), .alu_code(alu_code),
      .ar_ld_pc(ar_ld_pc), .ar_ld_ir(ar_ld_ir), .ar_ld_mem(ar_ld_mem),
      .ar_inc(ar_inc), .pc_inc(pc_inc), .pc_ld_ar(pc_ld_ar), .ir_ld(ir_ld),
      .dr_ld(dr_ld), .dr_inc(dr_inc), .ac_ld(ac_ld), .e_ld(e_ld),
      .mem_req(mem_req), .mem_we(mem_we), .mem_wsel(mem_wsel),
      .halted(halted), .state(state)
   );

   assign strb = {halted, ar_ld_pc, ar_ld_ir, ar_ld_mem, ar_inc, pc_inc, pc_ld_ar,
                  ir_ld, dr_ld, dr_inc, ac_ld, e_ld, mem_req, mem_we};

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int idx, input logic [15:0] act,
                        input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s row %0d: got %h expected %h", name, idx, act, exp);
      end
   endtask

   task automatic v(input state_t st, input logic st_in, input logic [15:0] i,
                    input logic ack, input logic ainc, input logic dz,
                    input logic [3:0] alu, input logic [13:0] s, input logic [1:0] ws);
      vec_t r;
      r.st = st; r.start = st_in; r.ir = i; r.ack = ack; r.ainc = ainc; r.dz = dz;
      r.alu = alu; r.strb = s; r.wsel = ws;
      vecs.push_back(r);
   endtask

   // T0/T1/T2 of any instruction, zero-wait fetch
   task automatic fetch(input logic [15:0] i, input logic [13:0] t2_strb);
      v(S_T0, 0, i, 0, 0, 0, 4'h0, APC, 0);
      v(S_T1, 0, i, 1, 0, 0, 4'h0, RQ | IRL | PINC, 0);
      v(S_T2, 0, i, 0, 0, 0, 4'h0, t2_strb, 0);
   endtask

   task automatic build_table();
      v(S_IDLE, 0, 16'h0, 0, 0, 0, 4'h0, H, 0);
      v(S_IDLE, 1, 16'h0, 0, 0, 0, 4'h0, H, 0);
      // ADD direct
      fetch(16'h1123, AIR);
      v(S_RD,   0, 16'h1123, 1, 0, 0, 4'h0, RQ | DRL, 0);
      v(S_EXEC, 0, 16'h1123, 0, 0, 0, 4'h1, ACL | EL, 0);
      // AND indirect, three wait cycles in IND
      fetch(16'h8100, AIR);
      v(S_IND,  0, 16'h8100, 0, 0, 0, 4'h0, RQ, 0);
      v(S_IND,  0, 16'h8100, 0, 0, 0, 4'h0, RQ, 0);
      v(S_IND,  0, 16'h8100, 0, 0, 0, 4'h0, RQ, 0);
      v(S_IND,  0, 16'h8100, 1, 0, 0, 4'h0, RQ | AMEM, 0);
      v(S_RD,   0, 16'h8100, 1, 0, 0, 4'h0, RQ | DRL, 0);
      v(S_EXEC, 0, 16'h8100, 0, 0, 0, 4'h0, ACL, 0);
      // CLA + CMA
      fetch(16'h7A00, 14'h0);
      v(S_RR,   0, 16'h7A00, 0, 0, 0, 4'b0110, ACL, 0);
      v(S_RR,   0, 16'h7A00, 0, 0, 0, 4'b0011, ACL, 0);
      // SPA + SZA, skip on SPA only: one pc_inc in the SZA cycle
      fetch(16'h7014, 14'h0);
      v(S_RR,   0, 16'h7014, 0, 1, 0, 4'b1010, 14'h0, 0);
      v(S_RR,   0, 16'h7014, 0, 0, 0, 4'b1100, PINC, 0);
      // ISZ with DR reaching zero
      fetch(16'h6050, AIR);
      v(S_RD,      0, 16'h6050, 1, 0, 0, 4'h0, RQ | DRL, 0);
      v(S_ISZ_INC, 0, 16'h6050, 0, 0, 0, 4'h0, DRI, 0);
      v(S_WR,      0, 16'h6050, 1, 0, 1, 4'h0, RQ | WE | PINC, WSEL_DR);
      // STA with one wait cycle
      fetch(16'h3005, AIR);
      v(S_WR,   0, 16'h3005, 0, 0, 0, 4'h0, RQ | WE, WSEL_AC);
      v(S_WR,   0, 16'h3005, 1, 0, 0, 4'h0, RQ | WE, WSEL_AC);
      // BSA
      fetch(16'h5010, AIR);
      v(S_WR,   0, 16'h5010, 1, 0, 0, 4'h0, RQ | WE | AINC, WSEL_PC);
      v(S_BSA2, 0, 16'h5010, 0, 0, 0, 4'h0, PLD, 0);
      // BUN
      fetch(16'h4020, AIR);
      v(S_EXEC, 0, 16'h4020, 0, 0, 0, 4'h0, PLD, 0);
      // HLT, stray ack in IDLE ignored, then resume
      fetch(16'h7001, 14'h0);
      v(S_RR,   0, 16'h7001, 0, 0, 0, 4'h0, 14'h0, 0);
      v(S_IDLE, 0, 16'h7001, 1, 0, 0, 4'h0, H, 0);
      v(S_IDLE, 1, 16'h7001, 0, 0, 0, 4'h0, H, 0);
      // SZA + HLT: pending skip still applied on the HLT cycle
      fetch(16'h7005, 14'h0);
      v(S_RR,   0, 16'h7005, 0, 1, 0, 4'b1100, 14'h0, 0);
      v(S_RR,   0, 16'h7005, 0, 0, 0, 4'h0, PINC, 0);
      v(S_IDLE, 1, 16'h7005, 0, 0, 0, 4'h0, H, 0);
      // ISZ with DR non-zero: no skip
      fetch(16'h6050, AIR);
      v(S_RD,      0, 16'h6050, 1, 0, 0, 4'h0, RQ | DRL, 0);
      v(S_ISZ_INC, 0, 16'h6050, 0, 0, 0, 4'h0, DRI, 0);
      v(S_WR,      0, 16'h6050, 1, 0, 0, 4'h0, RQ | WE, WSEL_DR);
      v(S_T0,      0, 16'h0000, 0, 0, 0, 4'h0, APC, 0);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; ir = 16'h0; alu_inc = 1'b0;
      dr_zero = 1'b0; mem_ack = 1'b0;
      build_table();
      repeat (2) @(negedge clk);
      check("reset_state", -1, 16'(state), 16'(S_IDLE));
      check("reset_strobes", -1, 16'(strb), 16'(H));
      check("reset_alu", -1, 16'(alu_code), 16'h0);
      rst_n = 1'b1;

      for (int k = 0; k < vecs.size(); k++) begin
         @(negedge clk);
         start   = vecs[k].start;
         ir      = vecs[k].ir;
         mem_ack = vecs[k].ack;
         alu_inc = vecs[k].ainc;
         dr_zero = vecs[k].dz;
         #1;
         check("state", k, 16'(state), 16'(vecs[k].st));
         check("alu_code", k, 16'(alu_code), 16'(vecs[k].alu));
         check("strobes", k, 16'(strb), 16'(vecs[k].strb));
         check("mem_wsel", k, 16'(mem_wsel), 16'(vecs[k].wsel));
      end

      // Reset while T1 waits for ack: outputs drop without a clock edge
      @(negedge clk);
      start = 1'b0; mem_ack = 1'b0; ir = 16'h1123;
      #1;
      check("t1_wait_state", 0, 16'(state), 16'(S_T1));
      check("t1_wait_req", 0, 16'(mem_req), 16'h1);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_req", 0, 16'(mem_req), 16'h0);
      check("async_rst_halted", 0, 16'(halted), 16'h1);
      check("async_rst_state", 0, 16'(state), 16'(S_IDLE));
      check("async_rst_strobes", 0, 16'(strb), 16'(H));
      @(negedge clk);
      rst_n = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      #1;
      check("restart_state", 0, 16'(state), 16'(S_T0));
      check("restart_strobes", 0, 16'(strb), 16'(APC));
      @(negedge clk);
      mem_ack = 1'b1;
      #1;
      check("restart_fetch", 0, 16'(strb), 16'(RQ | IRL | PINC));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
